nq_exec_unit: RTL and testbench



---
 rtl/nq_exec_pkg.sv | 88 ++++++++
 rtl/nq_alu.sv | 40 ++++
 rtl/nq_exec_unit.sv | 209 ++++++++++++++++++++
 tb/tb_nq_exec_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nq_exec_pkg.sv
// nq_exec_pkg: shared definitions for the nqcpu execution back-end.
// Holds opcode/ALU-op constants, the one-hot sequencer state encoding,
// branch condition codes and the packed 33-bit control word.
package nq_exec_pkg;

  // Instruction opcodes, instr[15:12]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SHIFT = 4'h7;
  localparam logic [3:0] OP_LDL   = 4'h8;
  localparam logic [3:0] OP_LDH   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_CMP   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_BR    = 4'hD;

  // ALU operation codes carried in the control word
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_NOT   = 4'h5;
  localparam logic [3:0] ALU_SHL   = 4'h6;
  localparam logic [3:0] ALU_SHR   = 4'h7;
  localparam logic [3:0] ALU_PASSB = 4'h8;

  // One-hot sequencer state; bit index matches dbg_state
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_FETCH  = 4'b0010,
    ST_DECODE = 4'b0100,
    ST_EXEC   = 4'b1000
  } state_e;

  // Branch condition codes, instr[11:10]
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_NZ     = 2'b11;

  // Control word, MSB first
  typedef struct packed {
    logic       valid;     // 32
    logic [3:0] alu_op;    // 31:28
    logic [2:0] rd;        // 27:25
    logic [2:0] ra;        // 24:22
    logic [2:0] rb;        // 21:19
    logic       reg_we;    // 18
    logic       hb;        // 17
    logic       lb;        // 16
    logic       use_imm;   // 15
    logic       set_flags; // 14
    logic       is_jump;   // 13
    logic       is_branch; // 12
    logic [1:0] cond;      // 11:10
    logic [9:0] rsvd;      // 9:0
  } ctrl_t;

  localparam int CTRL_W         = 33;
  localparam int CTRL_VALID_BIT = 32;
  localparam int CTRL_ALUOP_LSB = 28;
  localparam int CTRL_RD_LSB    = 25;
  localparam int CTRL_RA_LSB    = 22;
  localparam int CTRL_RB_LSB    = 19;
  localparam int CTRL_COND_LSB  = 10;

  function automatic logic cond_met(input logic [1:0] cond, input logic c, input logic z);
    case (cond)
      COND_ALWAYS: cond_met = 1'b1;
      COND_Z:      cond_met = z;
      COND_C:      cond_met = c;
      default:     cond_met = ~z;
    endcase
  endfunction

  // Logic ops leave C alone; arithmetic and shifts update it
  function automatic logic alu_sets_carry(input logic [3:0] alu_op);
    alu_sets_carry = (alu_op == ALU_ADD) || (alu_op == ALU_SUB) ||
                     (alu_op == ALU_SHL) || (alu_op == ALU_SHR);
  endfunction

endpackage

// File: rtl/nq_alu.sv
// nq_alu: combinational 16-bit ALU. carry is carry-out for ADD, borrow
// for SUB and the shifted-out bit for shifts; 0 otherwise.
module nq_alu
  import nq_exec_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  aluOp,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  // Result and carry selection
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (aluOp)
      ALU_ADD:   {carry, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB:   {carry, result} = {1'b0, a} - {1'b0, b};
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOT:   result = ~a;
      ALU_SHL: begin
        result = {a[14:0], 1'b0};
        carry  = a[15];
      end
      ALU_SHR: begin
        result = {1'b0, a[15:1]};
        carry  = a[0];
      end
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == 16'h0000);

endmodule

// File: rtl/nq_exec_unit.sv
// nq_exec_unit: sequencer, decode register and execute stage of nqcpu.
// Optional feature macro: NQ_EXEC_SHIFT_EN enables SHL/SHR on opcode 7;
// without it opcode 7 is a NOP.
//
// state  | meaning
// -------+-----------------------------------------------
// RESET  | after reset; moves to FETCH next cycle
// FETCH  | waiting for instruction; held while needWait
// DECODE | latch control word, immediate and pc
// EXEC   | ALU, register write, flags and branch resolve
module nq_exec_unit
  import nq_exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        needWait,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        alu_en,
  output logic        incr_pc,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  output logic [2:0]  rf_regA,
  output logic [2:0]  rf_regB,
  output logic [2:0]  rf_regDest,
  input  logic [15:0] rf_dataA,
  input  logic [15:0] rf_dataB,
  output logic [15:0] rf_dataIn,
  output logic        rf_we,
  output logic        rf_hb,
  output logic        rf_lb,
  output logic        setPC,
  output logic [15:0] setPCValue,
  output logic [32:0] ctrl_out,
  output logic [9:0]  dbg_state,
  output logic [1:0]  dbg_statusreg
);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0]  flags_q, flags_d;   // {C, Z}

  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        exec_ok;

  // State and decode/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  // Sequencer next state and stage enables
  always_comb begin
    state_d   = state_q;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    alu_en    = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH: begin
        fetch_en = 1'b1;
        if (!needWait) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        decode_en = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        alu_en  = 1'b1;
        state_d = ST_FETCH;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  assign incr_pc = fetch_en & ~needWait;

  // Instruction decode into control word and immediate
  always_comb begin
    ctrl_d = ctrl_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    if (decode_en) begin
      ctrl_d       = '0;
      ctrl_d.valid = 1'b1;
      ctrl_d.rd    = instr_in[11:9];
      ctrl_d.ra    = instr_in[8:6];
      ctrl_d.rb    = instr_in[5:3];
      imm_d        = '0;
      pc_d         = pc_in;
      case (instr_in[15:12])
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
          case (instr_in[15:12])
            OP_ADD:  ctrl_d.alu_op = ALU_ADD;
            OP_SUB:  ctrl_d.alu_op = ALU_SUB;
            OP_AND:  ctrl_d.alu_op = ALU_AND;
            OP_OR:   ctrl_d.alu_op = ALU_OR;
            OP_XOR:  ctrl_d.alu_op = ALU_XOR;
            default: ctrl_d.alu_op = ALU_NOT;
          endcase
          ctrl_d.reg_we    = 1'b1;
          ctrl_d.hb        = 1'b1;
          ctrl_d.lb        = 1'b1;
          ctrl_d.set_flags = 1'b1;
        end
        OP_SHIFT: begin
`ifdef NQ_EXEC_SHIFT_EN
          ctrl_d.alu_op    = instr_in[0] ? ALU_SHR : ALU_SHL;
          ctrl_d.reg_we    = 1'b1;
          ctrl_d.hb        = 1'b1;
          ctrl_d.lb        = 1'b1;
          ctrl_d.set_flags = 1'b1;
`else
          // shifter not built: behaves as NOP
          ctrl_d.alu_op    = ALU_ADD;
`endif
        end
        OP_LDL: begin
          ctrl_d.alu_op  = ALU_PASSB;
          ctrl_d.reg_we  = 1'b1;
          ctrl_d.lb      = 1'b1;
          ctrl_d.use_imm = 1'b1;
          imm_d          = {8'h00, instr_in[7:0]};
        end
        OP_LDH: begin
          ctrl_d.alu_op  = ALU_PASSB;
          ctrl_d.reg_we  = 1'b1;
          ctrl_d.hb      = 1'b1;
          ctrl_d.use_imm = 1'b1;
          imm_d          = {instr_in[7:0], 8'h00};
        end
        OP_ADDI: begin
          ctrl_d.alu_op    = ALU_ADD;
          ctrl_d.reg_we    = 1'b1;
          ctrl_d.hb        = 1'b1;
          ctrl_d.lb        = 1'b1;
          ctrl_d.use_imm   = 1'b1;
          ctrl_d.set_flags = 1'b1;
          imm_d            = {{10{instr_in[5]}}, instr_in[5:0]};
        end
        OP_CMP: begin
          ctrl_d.alu_op    = ALU_SUB;
          ctrl_d.set_flags = 1'b1;
        end
        OP_JMP:  ctrl_d.is_jump = 1'b1;
        OP_BR: begin
          ctrl_d.is_branch = 1'b1;
          ctrl_d.cond      = instr_in[11:10];
          imm_d            = {{5{instr_in[9]}}, instr_in[9:0], 1'b0};
        end
        default: ctrl_d.alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_b = ctrl_q.use_imm ? imm_q : rf_dataB;

  nq_alu u_alu (
    .a      (rf_dataA),
    .b      (alu_b),
    .aluOp  (ctrl_q.alu_op),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // A reset landing in EXEC must suppress the write and the branch
  assign exec_ok = alu_en & rst_n;

  // Execute-stage outputs and flag update
  always_comb begin
    rf_we      = exec_ok & ctrl_q.reg_we;
    rf_hb      = alu_en & ctrl_q.hb;
    rf_lb      = alu_en & ctrl_q.lb;
    rf_dataIn  = alu_result;
    setPC      = exec_ok & (ctrl_q.is_jump |
                 (ctrl_q.is_branch & cond_met(ctrl_q.cond, flags_q[1], flags_q[0])));
    setPCValue = ctrl_q.is_jump ? rf_dataA : (pc_q + imm_q);
    flags_d    = flags_q;
    if (exec_ok && ctrl_q.set_flags) begin
      flags_d[0] = alu_zero;
      if (alu_sets_carry(ctrl_q.alu_op)) flags_d[1] = alu_carry;
    end
  end

  assign rf_regA       = ctrl_q.ra;
  assign rf_regB       = ctrl_q.rb;
  assign rf_regDest    = ctrl_q.rd;
  assign ctrl_out      = ctrl_q;
  assign dbg_state     = {6'b000000, state_q};
  assign dbg_statusreg = flags_q;

endmodule

// File: tb/tb_nq_exec_unit.sv
// tb_nq_exec_unit: directed sequences plus random instructions checked
// against an arithmetic reference model of the instruction set. The bench
// also plays the role of the external register file.
module tb_nq_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        needWait = 1'b0;
  logic        fetch_en, decode_en, alu_en, incr_pc;
  logic [15:0] instr_in = '0;
  logic [15:0] pc_in = '0;
  logic [2:0]  rf_regA, rf_regB, rf_regDest;
  logic [15:0] rf_dataA, rf_dataB, rf_dataIn;
  logic        rf_we, rf_hb, rf_lb, setPC;
  logic [15:0] setPCValue;
  logic [32:0] ctrl_out;
  logic [9:0]  dbg_state;
  logic [1:0]  dbg_statusreg;

  logic [15:0] rf_mem [8];
  logic [15:0] m_regs [8];
  logic        m_c, m_z;

  logic        e_we, e_hb, e_lb, e_setpc, e_c, e_z;
  logic [2:0]  e_dest;
  logic [15:0] e_data, e_target;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rf_dataA = rf_mem[rf_regA];
  assign rf_dataB = rf_mem[rf_regB];

  nq_exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .needWait      (needWait),
    .fetch_en      (fetch_en),
    .decode_en     (decode_en),
    .alu_en        (alu_en),
    .incr_pc       (incr_pc),
    .instr_in      (instr_in),
    .pc_in         (pc_in),
    .rf_regA       (rf_regA),
    .rf_regB       (rf_regB),
    .rf_regDest    (rf_regDest),
    .rf_dataA      (rf_dataA),
    .rf_dataB      (rf_dataB),
    .rf_dataIn     (rf_dataIn),
    .rf_we         (rf_we),
    .rf_hb         (rf_hb),
    .rf_lb         (rf_lb),
    .setPC         (setPC),
    .setPCValue    (setPCValue),
    .ctrl_out      (ctrl_out),
    .dbg_state     (dbg_state),
    .dbg_statusreg (dbg_statusreg)
  );

  task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_full(input int v);
    e_we = 1'b1; e_hb = 1'b1; e_lb = 1'b1;
    e_data = 16'(v % 65536);
  endtask

  // Expected execute behaviour from the instruction set rules
  task automatic model_exec(input logic [15:0] ins, input logic [15:0] pc);
    int a, b, r, imm, off;
    a = int'(m_regs[ins[8:6]]);
    b = int'(m_regs[ins[5:3]]);
    e_we = 1'b0; e_hb = 1'b0; e_lb = 1'b0; e_setpc = 1'b0;
    e_data = '0; e_target = '0; e_dest = ins[11:9];
    e_c = m_c; e_z = m_z;
    case (ins[15:12])
      4'h1: begin r = a + b; set_full(r); e_c = (r > 65535); e_z = (r % 65536 == 0); end
      4'h2, 4'hB: begin
        r = a - b;
        e_c = (r < 0);
        r = (r + 65536) % 65536;
        e_z = (r == 0);
        if (ins[15:12] == 4'h2) set_full(r);
      end
      4'h3: begin r = a & b; set_full(r); e_z = (r == 0); end
      4'h4: begin r = a | b; set_full(r); e_z = (r == 0); end
      4'h5: begin r = a ^ b; set_full(r); e_z = (r == 0); end
      4'h6: begin r = (~a) & 65535; set_full(r); e_z = (r == 0); end
`ifdef NQ_EXEC_SHIFT_EN
      4'h7: begin
        if (ins[0]) begin r = a / 2; e_c = (a % 2 == 1); end
        else begin r = (a * 2) % 65536; e_c = (a >= 32768); end
        set_full(r); e_z = (r == 0);
      end
`endif
      4'h8: begin e_we = 1'b1; e_lb = 1'b1; e_data = {8'h00, ins[7:0]}; end
      4'h9: begin e_we = 1'b1; e_hb = 1'b1; e_data = {ins[7:0], 8'h00}; end
      4'hA: begin
        imm = int'(ins[5:0]);
        if (imm >= 32) imm = imm - 64;
        r = a + ((imm + 65536) % 65536);
        set_full(r); e_c = (r > 65535); e_z = (r % 65536 == 0);
      end
      4'hC: begin e_setpc = 1'b1; e_target = 16'(a); end
      4'hD: begin
        off = int'(ins[9:0]);
        if (off >= 512) off = off - 1024;
        e_target = 16'((int'(pc) + 2 * off + 65536) % 65536);
        case (ins[11:10])
          2'b00: e_setpc = 1'b1;
          2'b01: e_setpc = m_z;
          2'b10: e_setpc = m_c;
          default: e_setpc = ~m_z;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic wait_fetch();
    int k = 0;
    while (dbg_state != 10'h002 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check_val("fetch_reached", dbg_state, 10'h002);
  endtask

  // One instruction from FETCH to the following FETCH; optional reset in EXEC
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] pc, input int waits,
                           input bit rst_exec);
    logic       w_we, w_hb, w_lb;
    logic [2:0] w_dest;
    logic [15:0] w_data;
    wait_fetch();
    instr_in = ins;
    pc_in    = pc;
    for (int w = 0; w < waits; w++) begin
      needWait = 1'b1;
      #1;
      check_val("wait_state", dbg_state, 10'h002);
      check_val("wait_incr", incr_pc, 1'b0);
      @(negedge clk);
    end
    needWait = 1'b0;
    #1;
    check_val("fetch_state", dbg_state, 10'h002);
    check_val("fetch_incr", incr_pc, 1'b1);
    @(negedge clk);
    needWait = 1'($urandom);
    #1;
    check_val("decode_state", dbg_state, 10'h004);
    check_val("decode_incr", incr_pc, 1'b0);
    @(negedge clk);
    needWait = 1'($urandom);
    model_exec(ins, pc);
    if (rst_exec) begin
      rst_n = 1'b0;
      #1;
      check_val("rst_exec_we", rf_we, 1'b0);
      check_val("rst_exec_setpc", setPC, 1'b0);
      @(negedge clk);
      check_val("rst_exec_next", dbg_state, 10'h001);
      check_val("rst_exec_flags", dbg_statusreg, 2'b00);
      check_val("rst_exec_ctrl", ctrl_out, 33'h0);
      m_c = 1'b0; m_z = 1'b0;
      rst_n = 1'b1;
      needWait = 1'b0;
      return;
    end
    #1;
    check_val("exec_state", dbg_state, 10'h008);
    check_val("exec_incr", incr_pc, 1'b0);
    check_val("exec_we", rf_we, e_we);
    if (e_we) begin
      check_val("exec_dest", rf_regDest, e_dest);
      check_val("exec_hb", rf_hb, e_hb);
      check_val("exec_lb", rf_lb, e_lb);
      if (e_lb) check_val("exec_data_lo", rf_dataIn[7:0], e_data[7:0]);
      if (e_hb) check_val("exec_data_hi", rf_dataIn[15:8], e_data[15:8]);
    end
    check_val("exec_setpc", setPC, e_setpc);
    if (e_setpc) check_val("exec_target", setPCValue, e_target);
    w_we = rf_we; w_hb = rf_hb; w_lb = rf_lb; w_dest = rf_regDest; w_data = rf_dataIn;
    @(negedge clk);
    needWait = 1'b0;
    if (w_we) begin
      if (w_hb) rf_mem[w_dest][15:8] = w_data[15:8];
      if (w_lb) rf_mem[w_dest][7:0]  = w_data[7:0];
    end
    if (e_we) begin
      if (e_hb) m_regs[e_dest][15:8] = e_data[15:8];
      if (e_lb) m_regs[e_dest][7:0]  = e_data[7:0];
    end
    m_c = e_c;
    m_z = e_z;
    check_val("post_state", dbg_state, 10'h002);
    check_val("post_flags", dbg_statusreg, {m_c, m_z});
    check_val("post_valid", ctrl_out[32], 1'b1);
    check_val("post_fields", ctrl_out[27:19], ins[11:3]);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 16'($urandom);
      m_regs[i] = rf_mem[i];
    end
    m_c = 1'b0;
    m_z = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_state", dbg_state, 10'h001);
    check_val("rst_incr", incr_pc, 1'b0);
    check_val("rst_we", rf_we, 1'b0);
    check_val("rst_setpc", setPC, 1'b0);
    check_val("rst_ctrl", ctrl_out, 33'h0);
    check_val("rst_flags", dbg_statusreg, 2'b00);
    check_val("rst_enables", {fetch_en, decode_en, alu_en}, 3'b000);
    rst_n = 1'b1;
    #1;
    check_val("first_state", dbg_state, 10'h001);
    @(negedge clk);

    run_instr(16'h0000, 16'h0000, 0, 1'b0);
    run_instr(16'h0000, 16'h0002, 3, 1'b0);

    run_instr(16'h8234, 16'h0004, 0, 1'b0);
    run_instr(16'h9212, 16'h0006, 0, 1'b0);
    check_val("r1_value", rf_mem[1], 16'h1234);
    run_instr(16'h86FF, 16'h0008, 0, 1'b0);
    run_instr(16'h96FF, 16'h000A, 0, 1'b0);
    run_instr(16'h8801, 16'h000C, 0, 1'b0);
    run_instr(16'h9800, 16'h000E, 0, 1'b0);
    run_instr(16'h14E0, 16'h0010, 0, 1'b0);
    check_val("add_wrap_flags", dbg_statusreg, 2'b11);
    check_val("add_wrap_r2", rf_mem[2], 16'h0000);
    run_instr(16'hD7FE, 16'h0010, 0, 1'b0);
    run_instr(16'hB0E0, 16'h0012, 0, 1'b0);
    run_instr(16'hD7FE, 16'h0010, 0, 1'b0);
    run_instr(16'h14E0, 16'h0014, 0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      run_instr(16'($urandom), 16'($urandom) & 16'hFFFE, int'($urandom_range(0, 2)), 1'b0);
    end

    wait_fetch();
    for (int i = 0; i < 8; i++) check_val("final_reg", rf_mem[i], m_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
